// File: rtl/sync_fifo_pkg.sv
// Shared constants, pointer/count types and the full/empty helper for the FIFO controller.
package sync_fifo_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_RAM_DEPTH  = 16;
  localparam int unsigned PTR_MAX_W      = 32;

  typedef logic [DEF_ADDR_WIDTH:0] ptr_t;
  typedef logic [DEF_ADDR_WIDTH:0] cnt_t;

  typedef struct packed {
    logic full;
    logic empty;
  } ptr_flags_t;

  // Pointers carry a wrap bit above aw address bits; equal -> empty, only wrap differs -> full.
  function automatic ptr_flags_t ptr_flags(input logic [PTR_MAX_W-1:0] wp,
                                           input logic [PTR_MAX_W-1:0] rp,
                                           input int unsigned          aw);
    logic [PTR_MAX_W-1:0] mask;
    logic [PTR_MAX_W-1:0] diff;
    mask = (PTR_MAX_W'(1) << (aw + 1)) - PTR_MAX_W'(1);
    diff = (wp ^ rp) & mask;
    ptr_flags.empty = (diff == '0);
    ptr_flags.full  = (diff == (PTR_MAX_W'(1) << aw));
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrapping pointer register with increment enable; also exposes the next value.
module sync_fifo_ptr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  output logic [W-1:0] ptr_o,
  output logic [W-1:0] ptr_d_o
);

  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q + W'(en_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o   = ptr_q;
  assign ptr_d_o = ptr_d;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for the single-clock FIFO driving a dual-port RAM.
// Define SYNC_FIFO_ERR_EN to build sticky overflow/underflow error registers.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RAM_DEPTH  = DEF_RAM_DEPTH,
  parameter int unsigned AF_LEVEL   = 14,
  parameter int unsigned AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_wr_allow,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_rd_allow,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  if (RAM_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_chk
    $error("sync_fifo_ctrl: RAM_DEPTH must equal 2**ADDR_WIDTH");
  end

  logic          do_wr;
  logic          do_rd;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  ptr_flags_t    flags_d;
  logic          full_q, empty_q, af_q, ae_q, af_d, ae_d, rd_valid_q;

  assign do_wr = wr_en & ~full_q;
  assign do_rd = rd_en & ~empty_q;

  sync_fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (do_wr),
    .ptr_o   (wr_ptr_q),
    .ptr_d_o (wr_ptr_d)
  );

  sync_fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (do_rd),
    .ptr_o   (rd_ptr_q),
    .ptr_d_o (rd_ptr_d)
  );

  // Flags derive from next-state pointers so they never lag the pointer registers.
  always_comb begin
    count_d = wr_ptr_d - rd_ptr_d;
    flags_d = ptr_flags(PTR_MAX_W'(wr_ptr_d), PTR_MAX_W'(rd_ptr_d), ADDR_WIDTH);
    af_d    = (32'(count_d) >= AF_LEVEL);
    ae_d    = (32'(count_d) <= AE_LEVEL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      full_q     <= flags_d.full;
      empty_q    <= flags_d.empty;
      af_q       <= af_d;
      ae_q       <= ae_d;
      rd_valid_q <= do_rd;
    end
  end

  assign ram_wr_allow = do_wr;
  assign ram_rd_allow = do_rd;
  assign ram_wr_addr  = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_rd_addr  = rd_ptr_q[ADDR_WIDTH-1:0];
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, unf_q;

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (wr_en & full_q);
      unf_q <= unf_q | (rd_en & empty_q);
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (ADDR_WIDTH=4, AF=14, AE=2).
module tb_sync_fifo_ctrl;
  import sync_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       ram_wr_allow, ram_rd_allow, rd_valid;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  ptr_t wp, rp;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.ADDR_WIDTH(4), .RAM_DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ram_wr_allow (ram_wr_allow),
    .ram_wr_addr  (ram_wr_addr),
    .ram_rd_allow (ram_rd_allow),
    .ram_rd_addr  (ram_rd_addr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    wp = '0;
    rp = '0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    wp = wp + ptr_t'(n);
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    rp = rp + ptr_t'(n);
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_tests++;
    if ({empty, almost_empty, full, almost_full, rd_valid, count} !== {5'b11000, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_flags: got e=%b ae=%b f=%b af=%b v=%b cnt=%0d, want 1 1 0 0 0 0",
               empty, almost_empty, full, almost_full, rd_valid, count);
    end
    n_tests++;
    if ({ram_wr_allow, ram_rd_allow, ram_wr_addr, ram_rd_addr, overflow, underflow} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_ram: got wa=%b ra=%b waddr=%0d raddr=%0d ov=%b un=%b, want all 0",
               ram_wr_allow, ram_rd_allow, ram_wr_addr, ram_rd_addr, overflow, underflow);
    end
  endtask

  task automatic test_fill();
    int exp_cnt;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1;
      #1;
      n_tests++;
      if (ram_wr_allow !== (i < 16) || (i < 16 && ram_wr_addr !== 4'(i))) begin
        n_fail++;
        $display("FAIL fill_allow[%0d]: got allow=%b addr=%0d, want allow=%b addr=%0d",
                 i, ram_wr_allow, ram_wr_addr, (i < 16), i);
      end
      tick();
      exp_cnt = (i < 16) ? i + 1 : 16;
      n_tests++;
      if (count !== 5'(exp_cnt) || almost_full !== (exp_cnt >= 14) || full !== (exp_cnt == 16) ||
          empty !== 1'b0 || almost_empty !== (exp_cnt <= 2)) begin
        n_fail++;
        $display("FAIL fill_flags[%0d]: got cnt=%0d af=%b f=%b e=%b ae=%b, want cnt=%0d af=%b f=%b e=0 ae=%b",
                 i, count, almost_full, full, empty, almost_empty, exp_cnt, (exp_cnt >= 14),
                 (exp_cnt == 16), (exp_cnt <= 2));
      end
    end
    wr_en = 1'b0;
    wp = 5'd16;
    n_tests++;
    if (overflow !== 1'b0 && !`ifdef SYNC_FIFO_ERR_EN 1'b1 `else 1'b0 `endif) begin
      n_fail++;
      $display("FAIL overflow_off: got %b, want 0", overflow);
    end
  endtask

  task automatic test_drain();
    int exp_cnt;
    for (int i = 0; i < 17; i++) begin
      rd_en = 1'b1;
      #1;
      n_tests++;
      if (ram_rd_allow !== (i < 16) || (i < 16 && ram_rd_addr !== 4'(i))) begin
        n_fail++;
        $display("FAIL drain_allow[%0d]: got allow=%b addr=%0d, want allow=%b addr=%0d",
                 i, ram_rd_allow, ram_rd_addr, (i < 16), i);
      end
      tick();
      exp_cnt = (i < 16) ? 15 - i : 0;
      n_tests++;
      if (count !== 5'(exp_cnt) || rd_valid !== (i < 16) || empty !== (exp_cnt == 0) ||
          almost_empty !== (exp_cnt <= 2) || full !== 1'b0 || almost_full !== (exp_cnt >= 14)) begin
        n_fail++;
        $display("FAIL drain_flags[%0d]: got cnt=%0d v=%b e=%b ae=%b f=%b af=%b, want cnt=%0d v=%b e=%b ae=%b f=0 af=%b",
                 i, count, rd_valid, empty, almost_empty, full, almost_full, exp_cnt, (i < 16),
                 (exp_cnt == 0), (exp_cnt <= 2), (exp_cnt >= 14));
      end
    end
    rd_en = 1'b0;
    rp = 5'd16;
  endtask

  task automatic test_streaming();
    push_n(5);
    tick();
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      #1;
      n_tests++;
      if (ram_wr_allow !== 1'b1 || ram_rd_allow !== 1'b1 || ram_wr_addr !== wp[3:0] ||
          ram_rd_addr !== rp[3:0]) begin
        n_fail++;
        $display("FAIL stream_ram[%0d]: got wa=%b ra=%b waddr=%0d raddr=%0d, want 1 1 %0d %0d",
                 i, ram_wr_allow, ram_rd_allow, ram_wr_addr, ram_rd_addr, wp[3:0], rp[3:0]);
      end
      tick();
      wp = wp + 5'd1;
      rp = rp + 5'd1;
      n_tests++;
      if (count !== 5'd5 || rd_valid !== 1'b1 ||
          {empty, almost_empty, full, almost_full} !== 4'b0000) begin
        n_fail++;
        $display("FAIL stream_flags[%0d]: got cnt=%0d v=%b e=%b ae=%b f=%b af=%b, want 5 1 0 0 0 0",
                 i, count, rd_valid, empty, almost_empty, full, almost_full);
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_simul_edges();
    do_reset();
    push_n(16);
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    n_tests++;
    if (ram_wr_allow !== 1'b0 || ram_rd_allow !== 1'b1) begin
      n_fail++;
      $display("FAIL full_both_allow: got wa=%b ra=%b, want 0 1", ram_wr_allow, ram_rd_allow);
    end
    tick();
    n_tests++;
    if (count !== 5'd15 || full !== 1'b0 || almost_full !== 1'b1 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_both_flags: got cnt=%0d f=%b af=%b v=%b, want 15 0 1 1",
               count, full, almost_full, rd_valid);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    rp = rp + 5'd1;
    pop_n(15);
    tick();
    wr_en = 1'b1;
    rd_en = 1'b1;
    #1;
    n_tests++;
    if (ram_wr_allow !== 1'b1 || ram_rd_allow !== 1'b0 || ram_wr_addr !== wp[3:0]) begin
      n_fail++;
      $display("FAIL empty_both_allow: got wa=%b ra=%b waddr=%0d, want 1 0 %0d",
               ram_wr_allow, ram_rd_allow, ram_wr_addr, wp[3:0]);
    end
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_tests++;
    if (count !== 5'd1 || rd_valid !== 1'b0 || empty !== 1'b0 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_both_flags: got cnt=%0d v=%b e=%b ae=%b, want 1 0 0 1",
               count, rd_valid, empty, almost_empty);
    end
  endtask

  task automatic test_errors();
    do_reset();
    push_n(16);
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    pop_n(3);
    n_tests++;
`ifdef SYNC_FIFO_ERR_EN
    if (overflow !== 1'b1 || underflow !== 1'b0 || count !== 5'd13) begin
      n_fail++;
      $display("FAIL overflow_sticky: got ov=%b un=%b cnt=%0d, want 1 0 13", overflow, underflow, count);
    end
`else
    if (overflow !== 1'b0 || underflow !== 1'b0 || count !== 5'd13) begin
      n_fail++;
      $display("FAIL overflow_tied: got ov=%b un=%b cnt=%0d, want 0 0 13", overflow, underflow, count);
    end
`endif
    do_reset();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tick();
    n_tests++;
`ifdef SYNC_FIFO_ERR_EN
    if (underflow !== 1'b1 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_sticky: got un=%b ov=%b v=%b, want 1 0 0", underflow, overflow, rd_valid);
    end
`else
    if (underflow !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL underflow_tied: got un=%b ov=%b v=%b, want 0 0 0", underflow, overflow, rd_valid);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    push_n(6);
    wr_en = 1'b1;
    rd_en = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({empty, almost_empty, full, almost_full, rd_valid, count} !== {5'b11000, 5'd0} ||
        ram_wr_addr !== 4'd0 || ram_rd_addr !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got e=%b ae=%b f=%b af=%b v=%b cnt=%0d wa=%0d ra=%0d ov=%b un=%b, want reset values",
               empty, almost_empty, full, almost_full, rd_valid, count, ram_wr_addr, ram_rd_addr,
               overflow, underflow);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got v=%b e=%b cnt=%0d, want 0 1 0", rd_valid, empty, count);
    end
  endtask

  initial begin
    wp = '0;
    rp = '0;
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_simul_edges();
    test_errors();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
